atm_session_driver: RTL and testbench

Synthesizable customer-side initiator for `MainModule`. It accepts high-level transaction commands (withdraw, deposit, inquiry, end-session) over a valid/ready port and drives the ATM's card, language, PIN, operation and amount inputs with correctly timed steps. It monitors `Check_balance`/`FinalBalance`, refuses infeasible requests via `home_in`, and returns one response per command. It replaces hand-timed `#delay` stimulus in system benches and serves as the front-panel sequencer in the integrated design.

---
 rtl/atm_session_driver_if.sv | 22 ++
 rtl/atm_session_driver.sv | 210 +++++++++++++++++++++
 tb/tb_atm_session_driver.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/atm_session_driver_if.sv
// Command/response port of the ATM session driver.
// master = command source, slave = atm_session_driver.
interface atm_session_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_amount;
  logic [3:0] cmd_pin;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_balance;

  modport master (
    output cmd_valid, cmd_op, cmd_amount, cmd_pin,
    input  cmd_ready, rsp_valid, rsp_status, rsp_balance
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amount, cmd_pin,
    output cmd_ready, rsp_valid, rsp_status, rsp_balance
  );
endinterface

// File: rtl/atm_session_driver.sv
// Customer-side sequencer for MainModule: turns withdraw/deposit/inquiry/exit
// commands into timed ATM front-panel steps and returns one response each.
module atm_session_driver #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  atm_session_driver_if.slave  bus,
  output logic                 Insert_card,
  output logic                 Language_chosen,
  output logic [3:0]           Pin,
  output logic [1:0]           Operation,
  output logic [5:0]           Deposit_Amount,
  output logic [5:0]           WithDraw_Amount,
  output logic                 exit,
  output logic                 home_in,
  input  logic [7:0]           Check_balance,
  input  logic [7:0]           FinalBalance
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] OP_WD   = 2'd0;
  localparam logic [1:0] OP_DEP  = 2'd1;
  localparam logic [1:0] OP_INQ  = 2'd2;
  localparam logic [1:0] OP_EXIT = 2'd3;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_NOFUNDS  = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_OVERFLOW = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_CARD, S_READY, S_SETUP, S_HOLD, S_SETTLE, S_HOME, S_EXIT, S_RESP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             session_q;
  logic [1:0]       op_q;
  logic [5:0]       amt_q;
  logic [7:0]       pre_q;

  logic       cmd_ready_q, rsp_valid_q;
  logic [1:0] rsp_status_q;
  logic [7:0] rsp_balance_q;
  logic       card_q, lang_q, exit_q, home_q;
  logic [3:0] pin_q;
  logic [1:0] oper_q;
  logic [5:0] dep_q, wd_q;

  logic       accept;
  logic       wd_short;
  logic       dep_ovf;
  logic [7:0] exp_bal;

  assign accept   = bus.cmd_valid & cmd_ready_q;
  assign wd_short = {2'b00, amt_q} > Check_balance;
  assign dep_ovf  = (9'(Check_balance) + 9'(amt_q)) > 9'd255;

  // Balance the ATM should report once the operation has settled.
  always_comb begin
    exp_bal = pre_q;
    case (op_q)
      OP_WD:   exp_bal = pre_q - 8'(amt_q);
      OP_DEP:  exp_bal = pre_q + 8'(amt_q);
      default: exp_bal = pre_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      session_q     <= 1'b0;
      op_q          <= OP_INQ;
      amt_q         <= '0;
      pre_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
      card_q        <= 1'b0;
      lang_q        <= 1'b0;
      pin_q         <= '0;
      oper_q        <= OP_INQ;
      dep_q         <= '0;
      wd_q          <= '0;
      exit_q        <= 1'b0;
      home_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      home_q      <= 1'b0;
      case (state_q)
        S_IDLE, S_READY: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            op_q        <= bus.cmd_op;
            amt_q       <= bus.cmd_amount;
            if (bus.cmd_op == OP_EXIT) begin
              if (state_q == S_READY) begin
                state_q <= S_EXIT;
                cnt_q   <= CNT_LOAD;
                oper_q  <= OP_EXIT;
                exit_q  <= 1'b1;
              end else begin
                state_q       <= S_RESP;
                rsp_valid_q   <= 1'b1;
                rsp_status_q  <= ST_OK;
                rsp_balance_q <= '0;
              end
            end else if (state_q == S_READY) begin
              state_q <= S_SETUP;
            end else begin
              // Opening a session: PIN is sent only here.
              state_q   <= S_CARD;
              cnt_q     <= CNT_LOAD;
              session_q <= 1'b1;
              card_q    <= 1'b1;
              lang_q    <= 1'b1;
              pin_q     <= bus.cmd_pin;
            end
          end
        end
        S_CARD: begin
          if (cnt_q == '0) state_q <= S_SETUP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_SETUP: begin
          pre_q <= Check_balance;
          if ((op_q == OP_WD && wd_short) || (op_q == OP_DEP && dep_ovf)) begin
            state_q <= S_HOME;
            home_q  <= 1'b1;
          end else begin
            state_q <= S_HOLD;
            cnt_q   <= CNT_LOAD;
            oper_q  <= op_q;
            wd_q    <= (op_q == OP_WD)  ? amt_q : 6'd0;
            dep_q   <= (op_q == OP_DEP) ? amt_q : 6'd0;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_SETTLE;
            cnt_q   <= CNT_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_balance_q <= FinalBalance;
            rsp_status_q  <= (FinalBalance == exp_bal) ? ST_OK : ST_MISMATCH;
            oper_q        <= OP_INQ;
            wd_q          <= '0;
            dep_q         <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_HOME: begin
          state_q       <= S_RESP;
          rsp_valid_q   <= 1'b1;
          rsp_status_q  <= (op_q == OP_WD) ? ST_NOFUNDS : ST_OVERFLOW;
          rsp_balance_q <= pre_q;
        end
        S_EXIT: begin
          if (cnt_q == '0) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_status_q  <= ST_OK;
            rsp_balance_q <= Check_balance;
            oper_q        <= OP_INQ;
            exit_q        <= 1'b0;
            card_q        <= 1'b0;
            lang_q        <= 1'b0;
            pin_q         <= '0;
            session_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          state_q     <= session_q ? S_READY : S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.rsp_balance = rsp_balance_q;

  assign Insert_card     = card_q;
  assign Language_chosen = lang_q;
  assign Pin             = pin_q;
  assign Operation       = oper_q;
  assign Deposit_Amount  = dep_q;
  assign WithDraw_Amount = wd_q;
  assign exit            = exit_q;
  assign home_in         = home_q;

endmodule

// File: tb/tb_atm_session_driver.sv
// Directed bench for atm_session_driver: expected responses are queued on
// command acceptance and matched against rsp_valid pulses (status, balance, edge).
module tb_atm_session_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       Insert_card, Language_chosen, exit, home_in;
  logic [3:0] Pin;
  logic [1:0] Operation;
  logic [5:0] Deposit_Amount, WithDraw_Amount;
  logic [7:0] Check_balance, FinalBalance;

  atm_session_driver_if bus ();

  atm_session_driver #(.HOLD_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .Insert_card     (Insert_card),
    .Language_chosen (Language_chosen),
    .Pin             (Pin),
    .Operation       (Operation),
    .Deposit_Amount  (Deposit_Amount),
    .WithDraw_Amount (WithDraw_Amount),
    .exit            (exit),
    .home_in         (home_in),
    .Check_balance   (Check_balance),
    .FinalBalance    (FinalBalance)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic [7:0] bal;
    int         edge_at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   e0 = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: each rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_rsp observed=1 expected=0 at edge %0d", cyc + 1);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_status",  32'(bus.rsp_status),  32'(e.st));
        chk("rsp_balance", 32'(bus.rsp_balance), 32'(e.bal));
        chk("rsp_edge",    32'(cyc + 1),         32'(e.edge_at));
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] amt, input logic [3:0] pin,
                      input bit push, input logic [1:0] st, input logic [7:0] bal,
                      input int lat);
    bit ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) ok = 1'b1;
    end
    chk("cmd_ready_wait", 32'(ok), 1);
    if (!ok) return;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_amount = amt;
    bus.cmd_pin    = pin;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.cmd_valid = 1'b0;
    if (push) begin
      e.st = st; e.bal = bal; e.edge_at = e0 + lat;
      sb.push_back(e);
    end
  endtask

  // Move to the negedge inside cycle k after the accept edge.
  task automatic goto(input int k);
    @(negedge clk);
    while (cyc < e0 + k - 1) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("rsp_drain", 32'(sb.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_amount = '0; bus.cmd_pin = '0;
    Check_balance = '0; FinalBalance = '0;
    repeat (3) @(negedge clk);
    chk("rst_operation", 32'(Operation), 2);
    chk("rst_card",      32'(Insert_card), 0);
    chk("rst_pin",       32'(Pin), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);

    // Deposit 10 from IDLE opens the session.
    Check_balance = 8'd100; FinalBalance = 8'd110;
    send(2'd1, 6'd10, 4'b1111, 1'b1, 2'd0, 8'd110, 8);
    goto(1);
    chk("dep_card",     32'(Insert_card), 1);
    chk("dep_lang",     32'(Language_chosen), 1);
    chk("dep_pin",      32'(Pin), 32'hF);
    chk("dep_ready_lo", 32'(bus.cmd_ready), 0);
    goto(3);
    chk("dep_setup_op", 32'(Operation), 2);
    goto(4);
    chk("dep_hold_op",  32'(Operation), 1);
    chk("dep_hold_amt", 32'(Deposit_Amount), 10);
    chk("dep_hold_wd",  32'(WithDraw_Amount), 0);
    drain();

    // Withdraw 20 within the open session.
    Check_balance = 8'd110; FinalBalance = 8'd90;
    send(2'd0, 6'd20, 4'b0000, 1'b1, 2'd0, 8'd90, 6);
    goto(2);
    chk("wd_op",   32'(Operation), 0);
    chk("wd_amt",  32'(WithDraw_Amount), 20);
    chk("wd_dep",  32'(Deposit_Amount), 0);
    chk("wd_card", 32'(Insert_card), 1);
    drain();

    // Withdraw 63 against 40: refused via home_in.
    Check_balance = 8'd40;
    send(2'd0, 6'd63, 4'b0000, 1'b1, 2'd1, 8'd40, 3);
    goto(2);
    chk("nofunds_home", 32'(home_in), 1);
    chk("nofunds_op",   32'(Operation), 2);
    chk("nofunds_wd",   32'(WithDraw_Amount), 0);
    goto(3);
    chk("nofunds_home_off", 32'(home_in), 0);
    drain();

    // Deposit 20 against 250 overflows; deposit 5 with stale ATM balance mismatches.
    Check_balance = 8'd250; FinalBalance = 8'd250;
    send(2'd1, 6'd20, 4'b0000, 1'b1, 2'd3, 8'd250, 3);
    drain();
    send(2'd1, 6'd5, 4'b0000, 1'b1, 2'd2, 8'd250, 6);
    drain();

    // Inquiry; a new cmd_pin must not reach the ATM.
    Check_balance = 8'd77; FinalBalance = 8'd77;
    send(2'd2, 6'd9, 4'b0011, 1'b1, 2'd0, 8'd77, 6);
    goto(2);
    chk("inq_op",  32'(Operation), 2);
    chk("inq_amt", 32'(Deposit_Amount), 0);
    chk("inq_pin", 32'(Pin), 32'hF);
    drain();

    // End session.
    Check_balance = 8'd55;
    send(2'd3, 6'd0, 4'b0000, 1'b1, 2'd0, 8'd55, 3);
    goto(1);
    chk("exit_flag", 32'(exit), 1);
    chk("exit_op",   32'(Operation), 3);
    goto(3);
    chk("exit_card_clr", 32'(Insert_card), 0);
    chk("exit_pin_clr",  32'(Pin), 0);
    chk("exit_off",      32'(exit), 0);
    drain();

    // End session with no card: immediate OK, balance 0.
    send(2'd3, 6'd0, 4'b0000, 1'b1, 2'd0, 8'd0, 1);
    drain();

    // Inquiry from IDLE re-sends the new PIN.
    Check_balance = 8'd30; FinalBalance = 8'd30;
    send(2'd2, 6'd0, 4'b0101, 1'b1, 2'd0, 8'd30, 8);
    goto(1);
    chk("reopen_pin",  32'(Pin), 32'h5);
    chk("reopen_card", 32'(Insert_card), 1);
    drain();

    // Reset mid-HOLD of a deposit: outputs drop at once, no response.
    Check_balance = 8'd30; FinalBalance = 8'd33;
    send(2'd1, 6'd3, 4'b0000, 1'b0, 2'd0, 8'd0, 0);
    goto(2);
    chk("pre_rst_dep", 32'(Deposit_Amount), 3);
    rst = 1'b1;
    #1;
    chk("midrst_dep",  32'(Deposit_Amount), 0);
    chk("midrst_op",   32'(Operation), 2);
    chk("midrst_card", 32'(Insert_card), 0);
    chk("midrst_pin",  32'(Pin), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_ready", 32'(bus.cmd_ready), 1);

    // Boundaries: withdraw exactly the balance, deposit up to exactly 255.
    Check_balance = 8'd30; FinalBalance = 8'd0;
    send(2'd0, 6'd30, 4'b1001, 1'b1, 2'd0, 8'd0, 8);
    drain();
    Check_balance = 8'd230; FinalBalance = 8'd255;
    send(2'd1, 6'd25, 4'b0000, 1'b1, 2'd0, 8'd255, 6);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
